// File: rtl/usr_cmd_sequencer_if.sv
// Command-side and shift-register-side signal bundle for usr_cmd_sequencer.
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both high;
// the master holds cmd_valid and all cmd_* fields stable until that edge, and cmd_valid never depends on cmd_ready.
interface usr_cmd_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_count;
   logic             cmd_fill;
   logic [1:0]       mode;
   logic [WIDTH-1:0] data_in;
   logic             serial_in_left;
   logic             serial_in_right;
   logic [WIDTH-1:0] usr_q;
   logic [WIDTH-1:0] result;
   logic             done;

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, usr_q,
      output cmd_ready, mode, data_in, serial_in_left, serial_in_right, result, done
   );

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, usr_q,
      input  cmd_ready, mode, data_in, serial_in_left, serial_in_right, result, done
   );
endinterface

// File: rtl/usr_cmd_sequencer.sv
// Turns load / shift-N commands into cycle-by-cycle mode, data and serial drive for a universal
// shift register, then captures its output and pulses done.
module usr_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   usr_cmd_sequencer_if.slave   bus,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SHIFT  = 2'd2,
      SETTLE = 2'd3
   } state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SHL   = 2'b10;
   localparam logic [1:0] OP_LDSHR = 2'b11;

   state_t           state;
   state_t           state_nxt;
   logic             armed;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] count_q;
   logic             fill_q;
   logic [CNT_W-1:0] remaining;
   logic [WIDTH-1:0] result_q;
   logic             done_q;
   logic             accept;
   logic             load_rem;

   // armed keeps cmd_ready low until the first edge after reset is released
   assign bus.cmd_ready = armed && (state == IDLE);
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign load_rem      = (state_nxt == SHIFT) && (state != SHIFT);
   assign bus.result    = result_q;
   assign bus.done      = done_q;
   assign state_dbg     = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         armed     <= 1'b0;
         op_q      <= 2'b00;
         data_q    <= '0;
         count_q   <= '0;
         fill_q    <= 1'b0;
         remaining <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         armed  <= 1'b1;
         done_q <= (state == SETTLE);
         if (state == SETTLE) begin
            result_q <= bus.usr_q;
         end
         if (accept) begin
            op_q    <= bus.cmd_op;
            data_q  <= bus.cmd_data;
            count_q <= bus.cmd_count;
            fill_q  <= bus.cmd_fill;
         end
         // On entry from IDLE the latched count is not yet visible, so take it from the bus
         if (load_rem) begin
            remaining <= (state == IDLE) ? bus.cmd_count : count_q;
         end else if (state == SHIFT) begin
            remaining <= remaining - CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt           = state;
      bus.mode            = 2'b00;
      bus.data_in         = '0;
      bus.serial_in_left  = 1'b0;
      bus.serial_in_right = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bus.cmd_op == OP_LOAD || bus.cmd_op == OP_LDSHR) begin
                  state_nxt = LOAD;
               end else if (bus.cmd_count != '0) begin
                  state_nxt = SHIFT;
               end else begin
                  state_nxt = SETTLE;
               end
            end
         end
         LOAD: begin
            bus.mode    = 2'b11;
            bus.data_in = data_q;
            state_nxt   = (op_q == OP_LDSHR && count_q != '0) ? SHIFT : SETTLE;
         end
         SHIFT: begin
            if (op_q == OP_SHL) begin
               bus.mode           = 2'b10;
               bus.serial_in_left = fill_q;
            end else begin
               bus.mode            = 2'b01;
               bus.serial_in_right = fill_q;
            end
            if (remaining == CNT_W'(1)) begin
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer driving a behavioural 4-bit universal shift register.
module tb_usr_cmd_sequencer;
   localparam int WIDTH = 4;
   localparam int CNT_W = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] state_dbg;
   logic [WIDTH-1:0] usr_reg;

   usr_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   usr_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // Universal shift register: 00 hold, 01 right (serial_in_right at MSB), 10 left (serial_in_left at LSB), 11 load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) usr_reg <= '0;
      else begin
         case (bus.mode)
            2'b01:   usr_reg <= {bus.serial_in_right, usr_reg[WIDTH-1:1]};
            2'b10:   usr_reg <= {usr_reg[WIDTH-2:0], bus.serial_in_left};
            2'b11:   usr_reg <= bus.data_in;
            default: usr_reg <= usr_reg;
         endcase
      end
   end
   assign bus.usr_q = usr_reg;

   typedef struct {
      logic [1:0]       op;
      logic [WIDTH-1:0] data;
      logic [CNT_W-1:0] count;
      logic             fill;
      logic [WIDTH-1:0] exp_res;
      bit               junk;
   } vec_t;

   vec_t vecs[9];
   int   n_cmp = 0;
   int   n_err = 0;
   logic [WIDTH-1:0] ref_q;
   logic [WIDTH-1:0] last_res;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the register word after a command, from plain arithmetic on the previous word
   function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] data,
                                              input int count, input logic fill,
                                              input logic [WIDTH-1:0] cur);
      int v;
      int top;
      top = 1 << WIDTH;
      v = int'(cur);
      if (op == 2'b00 || op == 2'b11) v = int'(data);
      if (op != 2'b00) begin
         for (int i = 0; i < count; i++) begin
            if (op == 2'b10) v = ((v * 2) % top) + int'(fill);
            else             v = (v / 2) + (int'(fill) * (top / 2));
         end
      end
      return WIDTH'(v);
   endfunction

   task automatic do_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                         input logic [CNT_W-1:0] count, input logic fill,
                         input logic [WIDTH-1:0] exp_res, input bit junk);
      logic [1:0] exp_q[$];
      logic [1:0] dir;
      logic [1:0] m;
      int         lat_exp;
      bit         seen;
      dir = (op == 2'b10) ? 2'b10 : 2'b01;
      if (op == 2'b00 || op == 2'b11) exp_q.push_back(2'b11);
      if (op != 2'b00) for (int i = 0; i < int'(count); i++) exp_q.push_back(dir);
      exp_q.push_back(2'b00);
      lat_exp = (op == 2'b00) ? 2 : (op == 2'b11) ? int'(count) + 2 : int'(count) + 1;
      for (int i = 0; i < 100 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
      if (bus.cmd_ready !== 1'b1) begin
         check("ready_timeout", 32'd0, 32'd1);
         return;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      bus.cmd_count = count;
      bus.cmd_fill  = fill;
      @(posedge clk);
      seen = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            check("latency", k - 1, lat_exp);
            check("result", bus.result, exp_res);
            check("done_mode", bus.mode, 2'b00);
            check("done_ready", bus.cmd_ready, 1'b1);
            last_res = exp_res;
            bus.cmd_valid = 1'b0;
         end else begin
            m = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
            check("mode", bus.mode, m);
            check("data_in", bus.data_in, (m == 2'b11) ? data : '0);
            check("serial_right", bus.serial_in_right, (m == 2'b01) ? fill : 1'b0);
            check("serial_left", bus.serial_in_left, (m == 2'b10) ? fill : 1'b0);
            check("ready_busy", bus.cmd_ready, 1'b0);
            check("result_hold", bus.result, last_res);
            if (junk) begin
               bus.cmd_op    = 2'($urandom_range(0, 3));
               bus.cmd_data  = WIDTH'($urandom_range(0, 15));
               bus.cmd_count = CNT_W'($urandom_range(0, 7));
               bus.cmd_fill  = 1'($urandom_range(0, 1));
            end
         end
      end
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
         bus.cmd_valid = 1'b0;
      end
   endtask

   initial begin
      vecs[0] = '{2'b00, 4'b1010, 3'd0, 1'b0, 4'b1010, 1'b0};
      vecs[1] = '{2'b01, 4'b1111, 3'd2, 1'b1, 4'b1110, 1'b0};
      vecs[2] = '{2'b10, 4'b1111, 3'd2, 1'b0, 4'b1000, 1'b0};
      vecs[3] = '{2'b11, 4'b0011, 3'd4, 1'b0, 4'b0000, 1'b1};
      vecs[4] = '{2'b01, 4'b1111, 3'd0, 1'b1, 4'b0000, 1'b1};
      vecs[5] = '{2'b00, 4'b0110, 3'd0, 1'b1, 4'b0110, 1'b0};
      vecs[6] = '{2'b10, 4'b0000, 3'd7, 1'b1, 4'b1111, 1'b1};
      vecs[7] = '{2'b11, 4'b1001, 3'd1, 1'b1, 4'b1100, 1'b0};
      vecs[8] = '{2'b10, 4'b0101, 3'd0, 1'b0, 4'b1100, 1'b1};

      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = '0;
      bus.cmd_count = '0;
      bus.cmd_fill  = 1'b0;
      ref_q         = '0;
      last_res      = '0;
      repeat (2) @(negedge clk);
      check("rst_mode", bus.mode, 2'b00);
      check("rst_data_in", bus.data_in, 4'b0000);
      check("rst_serial_left", bus.serial_in_left, 1'b0);
      check("rst_serial_right", bus.serial_in_right, 1'b0);
      check("rst_result", bus.result, 4'b0000);
      check("rst_done", bus.done, 1'b0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ready_after", bus.cmd_ready, 1'b1);

      // Directed table; back-to-back since each call starts in the previous done cycle
      for (int i = 0; i < 9; i++) begin
         do_cmd(vecs[i].op, vecs[i].data, vecs[i].count, vecs[i].fill, vecs[i].exp_res, vecs[i].junk);
         ref_q = vecs[i].exp_res;
      end

      // Randomized commands against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [1:0]       op;
         logic [WIDTH-1:0] data;
         logic [CNT_W-1:0] count;
         logic             fill;
         logic [WIDTH-1:0] exp;
         op    = 2'($urandom_range(0, 3));
         data  = WIDTH'($urandom_range(0, 15));
         count = CNT_W'($urandom_range(0, 7));
         fill  = 1'($urandom_range(0, 1));
         exp   = model(op, data, int'(count), fill, ref_q);
         do_cmd(op, data, count, fill, exp, 1'($urandom_range(0, 1)));
         ref_q = exp;
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      // Asynchronous reset in the middle of a shift right of 5
      for (int i = 0; i < 100 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b01;
      bus.cmd_data  = 4'b1111;
      bus.cmd_count = 3'd5;
      bus.cmd_fill  = 1'b1;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_rst_mode", bus.mode, 2'b01);
      #2 reset = 1'b1;
      #1;
      check("midrst_mode", bus.mode, 2'b00);
      check("midrst_done", bus.done, 1'b0);
      check("midrst_result", bus.result, 4'b0000);
      check("midrst_serial_right", bus.serial_in_right, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      ref_q = '0;
      last_res = '0;
      @(posedge clk);
      #1;
      check("rel_ready", bus.cmd_ready, 1'b1);
      check("rel_done", bus.done, 1'b0);
      do_cmd(2'b00, 4'b0101, 3'd0, 1'b0, 4'b0101, 1'b0);
      @(negedge clk);
      check("done_pulse_end", bus.done, 1'b0);
      check("result_kept", bus.result, 4'b0101);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/usr_cmd_sequencer.md
Name: usr_cmd_sequencer

Overview:
- Command-driven controller that sits directly upstream of the 4-bit universal shift register.
- Accepts one command per valid/ready handshake: parallel load, shift right N, shift left N, or load-then-shift-right N.
- Drives the register's mode, data_in and serial inputs cycle by cycle, reads back its data_out, and reports the final word with a done pulse.
- Lets higher-level logic issue multi-cycle shift operations without hand-sequencing the mode lines.

Parameters:
- WIDTH, 4, data width; must match the shift register.
- CNT_W, 3, width of the shift count (max 2^CNT_W-1 shifts per command).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  00 load, 01 shift right, 10 shift left, 11 load then shift right.
- cmd_data  input  WIDTH  parallel load value (ops 00/11).
- cmd_count  input  CNT_W  number of shifts (ops 01/10/11).
- cmd_fill  input  1  serial bit inserted on each shift.
- mode  output  2  to shift register: 00 hold, 01 shift right, 10 shift left, 11 load.
- data_in  output  WIDTH  to shift register parallel input.
- serial_in_left  output  1  to shift register; enters at LSB on shift left.
- serial_in_right  output  1  to shift register; enters at MSB on shift right.
- usr_q  input  WIDTH  shift register data_out feedback.
- result  output  WIDTH  usr_q captured at command completion.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, immediate): state IDLE, mode=00, data_in=0, both serial outputs 0, result=0, done=0, all latched command fields 0. Reset mid-command aborts it with no done pulse. cmd_ready=1 from the first edge after deassertion.
- Handshake: accept on a rising edge with cmd_valid&cmd_ready. cmd_ready=1 only in IDLE. Inputs while busy are ignored; the master must hold cmd_valid until accepted. On accept, latch op, data, count and fill.
- mode, data_in and serial outputs decode only from registered state and latched fields, never from live cmd_* inputs.
- IDLE:
  - outputs mode=00.
  - on accept: op 00/11 go to LOAD; op 01/10 go to SHIFT if count!=0, else to SETTLE.
- LOAD (1 cycle):
  - outputs mode=11, data_in=latched data.
  - next state: SHIFT if op=11 and count!=0, else SETTLE.
- SHIFT:
  - Direction: mode=01 for op 01/11, mode=10 for op 10.
  - Fill bit: serial_in_right=fill when shifting right, serial_in_left=fill when shifting left; the unused serial output is 0. data_in=0.
  - Counting: remaining count loads from latched count on entry and decrements each cycle. Go to SETTLE in the cycle remaining==1, so exactly count shift edges occur.
- SETTLE (1 cycle): mode=00. usr_q now holds the final value. At the leaving edge: result<=usr_q, done<=1, go to IDLE.
- done is high for exactly one cycle, coincident with IDLE/cmd_ready=1. A new command may be accepted in that cycle.
- result holds until the next completion or reset.
- Latency from accept edge to done-asserted edge:
  - op 00: 2 edges.
  - op 01/10: N+1 edges.
  - op 11: N+2 edges.
  - count=0 shift: 1 edge.
- Back-to-back commands: zero idle gap beyond the done cycle.

Test Plan:
- Bench instantiates sequencer plus shift register. Load 1010 -> mode sequence 11,00; done 2 edges after accept; result=1010.
- Then shift right count=2 fill=1 -> mode 01,01,00; serial_in_right=1 while shifting; result=1110; done 3 edges after accept.
- Then shift left count=2 fill=0 -> mode 10,10,00; result=1000.
- Op 11 data=0011 count=4 fill=0 -> mode 11,01,01,01,01,00; result=0000; done 6 edges after accept.
- Shift right count=0 -> no 01 cycle, done after 1 edge, result equals prior register value. cmd_valid held with different cmd_* values while busy -> ignored, executed command unchanged.
- Assert reset mid-SHIFT (asynchronously, between edges) -> mode=00 and done=0 immediately, result=0. After release, cmd_ready=1 and load 0101 completes normally with result=0101.
